// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I funct3 width/sign codes for loads and stores
//   - FSM state encoding for lsu_unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RESP      = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed byte/halfword lane out of a read word
// and sign- or zero-extends it to XLEN.
//   rdata_i  : word returned by data_mem
//   offset_i : byte offset of the access within the word (addr[1:0])
//   funct3_i : load width/sign code (LB/LH/LW/LBU/LHU)
//   result_o : extended load result
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      offset_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] result_o
);

    logic        [7:0]  byte_lane;
    logic        [15:0] half_lane;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    assign byte_lane = rdata_i[{offset_i, 3'b000} +: 8];
    assign half_lane = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    assign byte_s    = byte_lane;
    assign half_s    = half_lane;

    // funct3[2] selects zero extension (LBU/LHU), otherwise sign extension.
    always_comb begin
        result_o = rdata_i;
        case (funct3_i[1:0])
            2'b00:   result_o = funct3_i[2] ? {{(XLEN-8){1'b0}}, byte_lane}
                                            : XLEN'(byte_s);
            2'b01:   result_o = funct3_i[2] ? {{(XLEN-16){1'b0}}, half_lane}
                                            : XLEN'(half_s);
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// lsu_unit: load/store unit between execute/writeback and data_mem.
//   req_*   : one request per valid/ready handshake (loads and stores)
//   flush   : squashes a pending load and blocks acceptance this cycle
//   dmem_*  : combinational data_mem strobes, active only in the accept cycle
//   rsp_*   : registered load result, rsp_valid pulses two cycles after accept
//   exc_*   : one-cycle pulse for a misaligned or illegal request
module lsu_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [RD_W-1:0] req_rd,
    output logic            dmem_re,
    output logic [XLEN-1:0] dmem_raddr,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_waddr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            rsp_valid,
    output logic [RD_W-1:0] rsp_rd,
    output logic [XLEN-1:0] rsp_data,
    output logic            exc_valid,
    output logic [XLEN-1:0] exc_addr,
    output logic            exc_is_store
);

    lsu_state_t      state_q, state_d;
    logic [1:0]      off_q;
    logic [2:0]      f3_q;
    logic [RD_W-1:0] rd_q;
    logic [XLEN-1:0] rsp_data_q;
    logic [RD_W-1:0] rsp_rd_q;
    logic            exc_valid_q;
    logic [XLEN-1:0] exc_addr_q;
    logic            exc_is_store_q;

    logic            accept;
    logic            legal;
    logic [XLEN-1:0] load_result;

    // Width/sign code legality combined with natural alignment.
    function automatic logic access_legal(input logic       is_store,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = ~is_store;
            F3_HU:   ok = ~is_store & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign req_ready = (state_q == IDLE) && !flush;
    // rst gating keeps data_mem quiet while reset is held.
    assign accept    = req_valid && req_ready && !rst;
    assign legal     = access_legal(req_is_store, req_funct3, req_addr[1:0]);

    assign dmem_raddr = {req_addr[XLEN-1:2], 2'b00};
    assign dmem_waddr = {req_addr[XLEN-1:2], 2'b00};

    // Store data is replicated across lanes; the strobes pick the live bytes.
    always_comb begin
        dmem_re    = 1'b0;
        dmem_we    = 1'b0;
        dmem_wstrb = 4'b0000;
        case (req_funct3[1:0])
            2'b00:   dmem_wdata = {4{req_wdata[7:0]}};
            2'b01:   dmem_wdata = {2{req_wdata[15:0]}};
            default: dmem_wdata = req_wdata;
        endcase
        if (accept && legal) begin
            if (req_is_store) begin
                dmem_we = 1'b1;
                case (req_funct3[1:0])
                    2'b00:   dmem_wstrb = 4'b0001 << req_addr[1:0];
                    2'b01:   dmem_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
                    default: dmem_wstrb = 4'b1111;
                endcase
            end else begin
                dmem_re = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept && legal && !req_is_store) state_d = LOAD_WAIT;
            LOAD_WAIT: state_d = flush ? IDLE : RESP;
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .rdata_i  (dmem_rdata),
        .offset_i (off_q),
        .funct3_i (f3_q),
        .result_o (load_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            off_q          <= '0;
            f3_q           <= '0;
            rd_q           <= '0;
            rsp_data_q     <= '0;
            rsp_rd_q       <= '0;
            exc_valid_q    <= 1'b0;
            exc_addr_q     <= '0;
            exc_is_store_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            exc_valid_q <= accept && !legal;
            if (accept) begin
                off_q <= req_addr[1:0];
                f3_q  <= req_funct3;
                rd_q  <= req_rd;
            end
            if (accept && !legal) begin
                exc_addr_q     <= req_addr;
                exc_is_store_q <= req_is_store;
            end
            // A flushed load leaves the previous result untouched.
            if (state_q == LOAD_WAIT && !flush) begin
                rsp_data_q <= load_result;
                rsp_rd_q   <= rd_q;
            end
        end
    end

    assign rsp_valid    = (state_q == RESP) && !flush;
    assign rsp_data     = rsp_data_q;
    assign rsp_rd       = rsp_rd_q;
    assign exc_valid    = exc_valid_q;
    assign exc_addr     = exc_addr_q;
    assign exc_is_store = exc_is_store_q;

endmodule
